// File: rtl/wb_pkg.sv
// Shared encodings for the write-back stage: result source selects and load formats.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_MEM = 2'b00,
    WB_EX  = 2'b01,
    WB_PC4 = 2'b10,
    WB_CSR = 2'b11
  } wbsel_e;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LD  = 3'b011,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_f3_e;

endpackage

// File: rtl/wb_stage_if.sv
// Write-back stage bus: upstream valid/ready handshake, operands, and register-file/forwarding outputs.
interface wb_stage_if #(
  parameter int XLEN = 32,
  parameter int RETW = 64
);
  logic            in_valid;
  logic            in_ready;
  logic            flush;
  logic [1:0]      WBSel;
  logic [XLEN-1:0] PC;
  logic [XLEN-1:0] data_from_EX;
  logic [XLEN-1:0] data_from_MEM;
  logic [XLEN-1:0] data_from_CSR;
  logic [2:0]      funct3;
  logic [2:0]      addr_lo;
  logic [4:0]      rd_in;
  logic            rd_we_in;
  logic            stall;
  logic            rd_we;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] rd_data;
  logic            fwd_valid;
  logic [4:0]      fwd_rd;
  logic [XLEN-1:0] fwd_data;
  logic [RETW-1:0] instret;

  modport master (
    output in_valid, flush, WBSel, PC, data_from_EX, data_from_MEM, data_from_CSR,
           funct3, addr_lo, rd_in, rd_we_in, stall,
    input  in_ready, rd_we, rd_addr, rd_data, fwd_valid, fwd_rd, fwd_data, instret
  );

  modport slave (
    input  in_valid, flush, WBSel, PC, data_from_EX, data_from_MEM, data_from_CSR,
           funct3, addr_lo, rd_in, rd_we_in, stall,
    output in_ready, rd_we, rd_addr, rd_data, fwd_valid, fwd_rd, fwd_data, instret
  );
endinterface

// File: rtl/load_align.sv
// Load formatter: picks byte/half/word/double at the load offset and sign- or zero-extends it.
// Purely combinational; offsets beyond the datapath width wrap onto the available lanes.
module load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_data,
  input  logic [2:0]      i_funct3,
  input  logic [2:0]      i_addr_lo,
  output logic [XLEN-1:0] o_data
);

  logic [63:0] w_d64;
  logic [2:0]  w_off;
  logic [7:0]  w_b;
  logic [15:0] w_h;
  logic [31:0] w_w;
  logic [63:0] w_ext;

  assign w_d64 = 64'(i_data);
  // Misaligned offsets simply lose their low bits through the lane slicing below.
  assign w_off = i_addr_lo & 3'(XLEN / 8 - 1);
  assign w_b   = w_d64[{w_off, 3'b000} +: 8];
  assign w_h   = w_d64[{w_off[2:1], 4'b0000} +: 16];
  assign w_w   = w_d64[{w_off[2], 5'b00000} +: 32];

  always_comb begin
    w_ext = '0;
    case (load_f3_e'(i_funct3))
      F3_LB:   w_ext = {{56{w_b[7]}}, w_b};
      F3_LBU:  w_ext = {56'd0, w_b};
      F3_LH:   w_ext = {{48{w_h[15]}}, w_h};
      F3_LHU:  w_ext = {48'd0, w_h};
      F3_LW:   w_ext = {{32{w_w[31]}}, w_w};
      F3_LD:   if (XLEN == 64) w_ext = w_d64;
      default: w_ext = '0;
    endcase
  end

  assign o_data = w_ext[XLEN-1:0];

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: selects/formats the result and holds it for one register-file write.
// Latency 1 cycle accept->rd_*; a held instruction under stall deasserts in_ready until it leaves.
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RETW = 64
) (
  input logic        clk,
  input logic        rst_n,
  wb_stage_if.slave  bus
);

  logic            r_held_valid;
  logic            r_held_we;
  logic [4:0]      r_rd_addr;
  logic [XLEN-1:0] r_rd_data;
  logic [RETW-1:0] r_instret;

  logic            w_in_ready;
  logic            w_accept;
  logic            w_wr_req;
  logic [XLEN-1:0] w_load;
  logic [XLEN-1:0] w_result;

  load_align #(.XLEN(XLEN)) u_load_align (
    .i_data    (bus.data_from_MEM),
    .i_funct3  (bus.funct3),
    .i_addr_lo (bus.addr_lo),
    .o_data    (w_load)
  );

  always_comb begin
    w_result = '0;
    case (wbsel_e'(bus.WBSel))
      WB_MEM: w_result = w_load;
      WB_EX:  w_result = bus.data_from_EX;
      WB_PC4: w_result = bus.PC + XLEN'(4);
      WB_CSR: w_result = bus.data_from_CSR;
      default: w_result = '0;
    endcase
  end

  assign w_in_ready = !bus.stall || !r_held_valid;
  assign w_accept   = bus.in_valid && w_in_ready;
  // Writes to x0 are dropped here so neither the register file nor forwarding sees them.
  assign w_wr_req   = r_held_valid && r_held_we && (r_rd_addr != 5'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_held_valid <= 1'b0;
      r_held_we    <= 1'b0;
      r_rd_addr    <= '0;
      r_rd_data    <= '0;
      r_instret    <= '0;
    end else if (bus.flush) begin
      r_held_valid <= 1'b0;
    end else begin
      if (r_held_valid && !bus.stall) r_instret <= r_instret + RETW'(1);
      if (w_accept) begin
        r_held_valid <= 1'b1;
        r_held_we    <= bus.rd_we_in;
        r_rd_addr    <= bus.rd_in;
        r_rd_data    <= w_result;
      end else if (!bus.stall) begin
        r_held_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.rd_we     = w_wr_req && !bus.stall;
  assign bus.rd_addr   = r_rd_addr;
  assign bus.rd_data   = r_rd_data;
  assign bus.fwd_valid = w_wr_req;
  assign bus.fwd_rd    = r_rd_addr;
  assign bus.fwd_data  = r_rd_data;
  assign bus.instret   = r_instret;

endmodule
